countdown_bcd_timer: RTL and testbench

COUNTDOWN_BCD_TIMER -- requirements
Module: countdown_bcd_timer

---
 rtl/countdown_bcd_timer.sv | 130 +++++++++++++
 tb/tb_countdown_bcd_timer.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_bcd_timer.sv
// rtl/countdown_bcd_timer.sv - MM:SS BCD countdown timer with strike-scaled decrement rate
module countdown_bcd_timer #(
    parameter int CLK_HZ = 27000000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        load,
    input  logic [15:0] load_bcd,
    input  logic        start,
    input  logic        stop,
    input  logic [1:0]  strikes,
    output logic [3:0]  min_tens,
    output logic [3:0]  min_ones,
    output logic [3:0]  sec_tens,
    output logic [3:0]  sec_ones,
    output logic        running,
    output logic        tick,
    output logic        expired,
    output logic        load_err
);

    localparam int CW = $clog2(CLK_HZ + 1);
    localparam logic [CW-1:0] PM1_SLOW = CW'(CLK_HZ - 1);
    localparam logic [CW-1:0] PM1_MID  = CW'((CLK_HZ * 3) / 4 - 1);
    localparam logic [CW-1:0] PM1_FAST = CW'(CLK_HZ / 2 - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RUN     = 2'd1;
    localparam logic [1:0] S_PAUSED  = 2'd2;
    localparam logic [1:0] S_EXPIRED = 2'd3;

    logic [1:0]    state;
    logic [CW-1:0] count;
    logic [CW-1:0] pm1;
    logic [15:0]   bcd;
    logic [15:0]   dec;
    logic          load_ok;
    logic          period_done;
    logic          dec_zero;
    logic          time_zero;

    assign {min_tens, min_ones, sec_tens, sec_ones} = bcd;
    assign running = (state == S_RUN);
    assign expired = (state == S_EXPIRED);

    always_comb begin
        case (strikes)
            2'd0:    pm1 = PM1_SLOW;
            2'd1:    pm1 = PM1_MID;
            default: pm1 = PM1_FAST;
        endcase
    end

    assign load_ok = (load_bcd[15:12] <= 4'd9) && (load_bcd[11:8] <= 4'd9) &&
                     (load_bcd[7:4] <= 4'd5) && (load_bcd[3:0] <= 4'd9);
    // >= rather than == so a mid-period rate increase fires at once instead of wrapping
    assign period_done = (count >= pm1);
    assign time_zero   = (bcd == 16'h0000);

    always_comb begin
        dec = bcd;
        if (bcd[3:0] != 4'd0) begin
            dec[3:0] = bcd[3:0] - 4'd1;
        end else begin
            dec[3:0] = 4'd9;
            if (bcd[7:4] != 4'd0) begin
                dec[7:4] = bcd[7:4] - 4'd1;
            end else begin
                dec[7:4] = 4'd5;
                if (bcd[11:8] != 4'd0) begin
                    dec[11:8] = bcd[11:8] - 4'd1;
                end else begin
                    dec[11:8]  = 4'd9;
                    dec[15:12] = bcd[15:12] - 4'd1;
                end
            end
        end
    end

    assign dec_zero = (dec == 16'h0000);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            count    <= '0;
            bcd      <= 16'h0000;
            tick     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            tick     <= 1'b0;
            load_err <= 1'b0;

            // Counting proceeds regardless of requests; a rejected load must not disturb it
            if (state == S_RUN) begin
                if (period_done) begin
                    count <= '0;
                    tick  <= 1'b1;
                    bcd   <= dec;
                    if (dec_zero) begin
                        state <= S_EXPIRED;
                    end
                end else begin
                    count <= count + CW'(1);
                end
            end

            if (load) begin
                if (load_ok && state != S_RUN) begin
                    bcd   <= load_bcd;
                    state <= S_IDLE;
                    count <= '0;
                end else begin
                    load_err <= 1'b1;
                end
            end else if (stop) begin
                if (state == S_RUN && !(period_done && dec_zero)) begin
                    state <= S_PAUSED;
                end
            end else if (start) begin
                if ((state == S_IDLE || state == S_PAUSED) && !time_zero) begin
                    state <= S_RUN;
                    if (state == S_IDLE) begin
                        count <= '0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_countdown_bcd_timer.sv
// tb/tb_countdown_bcd_timer.sv - scoreboard bench for countdown_bcd_timer at CLK_HZ=8
module tb_countdown_bcd_timer;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        load = 1'b0;
    logic [15:0] load_bcd = 16'h0000;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [1:0]  strikes = 2'd0;
    logic [3:0]  min_tens, min_ones, sec_tens, sec_ones;
    logic        running, tick, expired, load_err;

    typedef struct {
        int          at;
        logic [15:0] bcd;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    wire [15:0] shown = {min_tens, min_ones, sec_tens, sec_ones};

    countdown_bcd_timer #(.CLK_HZ(8)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .load     (load),
        .load_bcd (load_bcd),
        .start    (start),
        .stop     (stop),
        .strikes  (strikes),
        .min_tens (min_tens),
        .min_ones (min_ones),
        .sec_tens (sec_tens),
        .sec_ones (sec_ones),
        .running  (running),
        .tick     (tick),
        .expired  (expired),
        .load_err (load_err)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1);
    end

    // Every edge goes through here so each tick is matched against the scoreboard
    task automatic step();
        exp_t e;
        @(posedge clock);
        cyc++;
        #1;
        if (tick) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_tick cyc=%0d time=%h", cyc, shown);
            end else begin
                e = sb.pop_front();
                if (e.at !== cyc || e.bcd !== shown) begin
                    bad++;
                    $display("FAIL tick_sched got cyc=%0d time=%h want cyc=%0d time=%h",
                             cyc, shown, e.at, e.bcd);
                end
            end
        end
    endtask

    task automatic run_to(input int t);
        while (cyc < t) step();
    endtask

    task automatic expect_tick(input int at, input logic [15:0] b);
        exp_t e;
        e.at  = at;
        e.bcd = b;
        sb.push_back(e);
    endtask

    task automatic pulse_load(input logic [15:0] v);
        load = 1'b1;
        load_bcd = v;
        step();
        load = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic check_drained(input string name);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL %s missing_ticks got=%0d want=0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        #1 reset_n = 1'b0;
        #3;
        total++;
        if (shown !== 16'h0000) begin
            bad++;
            $display("FAIL reset_digits got=%h want=0000", shown);
        end
        total++;
        if ({running, tick, expired, load_err} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_flags got=%b want=0000", {running, tick, expired, load_err});
        end
        step();
        step();
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_count_basic();
        int c;
        strikes = 2'd0;
        pulse_load(16'h0130);
        total++;
        if (shown !== 16'h0130 || running !== 1'b0 || load_err !== 1'b0) begin
            bad++;
            $display("FAIL basic_load got=%h run=%b err=%b want=0130 0 0", shown, running, load_err);
        end
        c = cyc;
        expect_tick(c + 9, 16'h0129);
        expect_tick(c + 17, 16'h0128);
        expect_tick(c + 25, 16'h0127);
        pulse_start();
        total++;
        if (running !== 1'b1) begin
            bad++;
            $display("FAIL basic_running got=%b want=1", running);
        end
        run_to(c + 25);
        total++;
        if (shown !== 16'h0127) begin
            bad++;
            $display("FAIL basic_time got=%h want=0127", shown);
        end
        pulse_stop();
        total++;
        if (running !== 1'b0) begin
            bad++;
            $display("FAIL basic_stop got=%b want=0", running);
        end
        check_drained("basic");
    endtask

    task automatic test_borrow_expire();
        int c;
        pulse_load(16'h1000);
        c = cyc;
        expect_tick(c + 9, 16'h0959);
        pulse_start();
        run_to(c + 9);
        total++;
        if (shown !== 16'h0959) begin
            bad++;
            $display("FAIL borrow got=%h want=0959", shown);
        end
        pulse_stop();
        pulse_load(16'h0001);
        c = cyc;
        expect_tick(c + 9, 16'h0000);
        pulse_start();
        run_to(c + 8);
        total++;
        if (expired !== 1'b0 || running !== 1'b1) begin
            bad++;
            $display("FAIL pre_expire got exp=%b run=%b want 0 1", expired, running);
        end
        run_to(c + 9);
        total++;
        if (expired !== 1'b1 || running !== 1'b0 || shown !== 16'h0000) begin
            bad++;
            $display("FAIL expire got exp=%b run=%b time=%h want 1 0 0000", expired, running, shown);
        end
        pulse_start();
        run_to(cyc + 10);
        total++;
        if (expired !== 1'b1 || running !== 1'b0 || shown !== 16'h0000) begin
            bad++;
            $display("FAIL expire_hold got exp=%b run=%b time=%h want 1 0 0000", expired, running, shown);
        end
        check_drained("expire");
    endtask

    task automatic test_strikes();
        int c;
        pulse_load(16'h0010);
        total++;
        if (expired !== 1'b0 || shown !== 16'h0010) begin
            bad++;
            $display("FAIL expire_exit got exp=%b time=%h want 0 0010", expired, shown);
        end
        c = cyc;
        expect_tick(c + 7, 16'h0009);
        expect_tick(c + 11, 16'h0008);
        expect_tick(c + 15, 16'h0007);
        expect_tick(c + 21, 16'h0006);
        expect_tick(c + 25, 16'h0005);
        pulse_start();
        run_to(c + 6);
        strikes = 2'd2;
        run_to(c + 15);
        strikes = 2'd1;
        run_to(c + 21);
        strikes = 2'd3;
        run_to(c + 25);
        pulse_stop();
        strikes = 2'd0;
        total++;
        if (shown !== 16'h0005 || running !== 1'b0) begin
            bad++;
            $display("FAIL strikes_end got=%h run=%b want=0005 0", shown, running);
        end
        check_drained("strikes");
    endtask

    task automatic test_load_err();
        int c;
        pulse_load(16'h0060);
        total++;
        if (load_err !== 1'b1 || shown !== 16'h0005) begin
            bad++;
            $display("FAIL bad_sec_tens got err=%b time=%h want 1 0005", load_err, shown);
        end
        step();
        total++;
        if (load_err !== 1'b0) begin
            bad++;
            $display("FAIL err_pulse_width got=%b want=0", load_err);
        end
        pulse_load(16'hA000);
        total++;
        if (load_err !== 1'b1 || shown !== 16'h0005) begin
            bad++;
            $display("FAIL bad_min_tens got err=%b time=%h want 1 0005", load_err, shown);
        end
        pulse_load(16'h0020);
        total++;
        if (load_err !== 1'b0 || shown !== 16'h0020) begin
            bad++;
            $display("FAIL good_load got err=%b time=%h want 0 0020", load_err, shown);
        end
        c = cyc;
        expect_tick(c + 9, 16'h0019);
        expect_tick(c + 17, 16'h0018);
        pulse_start();
        run_to(c + 4);
        pulse_load(16'h0500);
        total++;
        if (load_err !== 1'b1 || running !== 1'b1 || shown !== 16'h0020) begin
            bad++;
            $display("FAIL run_load got err=%b run=%b time=%h want 1 1 0020", load_err, running, shown);
        end
        run_to(c + 17);
        pulse_stop();
        total++;
        if (shown !== 16'h0018) begin
            bad++;
            $display("FAIL run_load_after got=%h want=0018", shown);
        end
        check_drained("load_err");
    endtask

    task automatic test_pause_resume();
        int c;
        pulse_load(16'h0030);
        c = cyc;
        pulse_start();
        run_to(c + 4);
        pulse_stop();
        total++;
        if (running !== 1'b0) begin
            bad++;
            $display("FAIL pause got=%b want=0", running);
        end
        run_to(c + 8);
        expect_tick(c + 13, 16'h0029);
        pulse_start();
        total++;
        if (running !== 1'b1) begin
            bad++;
            $display("FAIL resume got=%b want=1", running);
        end
        run_to(c + 12);
        stop = 1'b1;
        step();
        stop = 1'b0;
        total++;
        if (running !== 1'b0 || shown !== 16'h0029 || expired !== 1'b0) begin
            bad++;
            $display("FAIL stop_on_tick got run=%b time=%h exp=%b want 0 0029 0", running, shown, expired);
        end
        load = 1'b1;
        load_bcd = 16'h0045;
        start = 1'b1;
        step();
        load = 1'b0;
        start = 1'b0;
        step();
        step();
        total++;
        if (shown !== 16'h0045 || running !== 1'b0) begin
            bad++;
            $display("FAIL load_start got time=%h run=%b want 0045 0", shown, running);
        end
        check_drained("pause");
    endtask

    task automatic test_reset_mid_run();
        pulse_start();
        step();
        step();
        step();
        total++;
        if (running !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset_run got=%b want=1", running);
        end
        #2 reset_n = 1'b0;
        #1;
        total++;
        if (shown !== 16'h0000 || {running, tick, expired, load_err} !== 4'b0000) begin
            bad++;
            $display("FAIL async_reset got time=%h flags=%b want 0000 0000",
                     shown, {running, tick, expired, load_err});
        end
        step();
        step();
        reset_n = 1'b1;
        pulse_start();
        repeat (9) step();
        total++;
        if (running !== 1'b0 || shown !== 16'h0000 || expired !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_start got run=%b time=%h exp=%b want 0 0000 0", running, shown, expired);
        end
        check_drained("reset_mid_run");
    endtask

    initial begin
        test_reset();
        test_count_basic();
        test_borrow_expire();
        test_strikes();
        test_load_err();
        test_pause_resume();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
